// File: rtl/fifo_frame_writer_pkg.sv
// Types and helpers shared by the frame writer and the read-side deframer.
package fifo_frame_writer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_TRAILER = 2'd2
   } state_e;

   localparam int SEQ_W      = 8;
   localparam int LEN_W      = 8;
   localparam int MAX_DATA_W = 64;

   // The trailer flag is the bit just above the payload word.
   function automatic int trailer_flag(input int data_width);
      return data_width;
   endfunction

   // Trailer word: flag at bit data_width, then zero pad, then {seq, len}.
   function automatic logic [MAX_DATA_W:0] pack_trailer(input logic [SEQ_W-1:0] seq,
                                                        input logic [LEN_W-1:0] len,
                                                        input int data_width);
      logic [MAX_DATA_W:0] w;
      w = '0;
      w[SEQ_W+LEN_W-1:0] = {seq, len};
      w = w | ((MAX_DATA_W+1)'(1) << trailer_flag(data_width));
      return w;
   endfunction

endpackage

// File: rtl/fifo_frame_writer_if.sv
// Upstream word stream plus FIFO write port of the frame writer.
interface fifo_frame_writer_if
   import fifo_frame_writer_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 4
);
   logic [DATA_WIDTH-1:0] s_data;
   logic                  s_valid;
   logic                  s_ready;
   logic                  flush;
   logic                  fifo_full;
   logic [ADDR_WIDTH:0]   fifo_count;
   logic                  fifo_wr_en;
   logic [DATA_WIDTH:0]   fifo_wr_data;
   logic [SEQ_W-1:0]      frame_seq;
   logic                  overflow_err;
   state_e                dbg_state;

   // A word transfers on a rising edge where s_valid & s_ready; s_valid/s_data
   // hold until then, and s_ready never depends on s_valid.
   modport master (
      input  s_data, s_valid, flush, fifo_full, fifo_count,
      output s_ready, fifo_wr_en, fifo_wr_data, frame_seq, overflow_err, dbg_state
   );

   modport slave (
      output s_data, s_valid, flush, fifo_full, fifo_count,
      input  s_ready, fifo_wr_en, fifo_wr_data, frame_seq, overflow_err, dbg_state
   );
endinterface

// File: rtl/fifo_frame_writer.sv
// Groups a word stream into trailer-terminated frames and writes each frame
// into the async FIFO only once the whole frame is known to fit.
module fifo_frame_writer
   import fifo_frame_writer_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 4,
   parameter int FRAME_LEN  = 8
) (
   input  logic                 wr_clk,
   input  logic                 wr_rst_n,
   fifo_frame_writer_if.master  bus
);

   localparam int CW = ADDR_WIDTH + 2;
   localparam logic [CW-1:0]    NEED     = CW'(FRAME_LEN + 1);
   localparam logic [CW-1:0]    CAP      = CW'(2 ** ADDR_WIDTH);
   localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(FRAME_LEN);

   state_e                state_q, state_d;
   logic [LEN_W-1:0]      wc_q, wc_d;
   logic [SEQ_W-1:0]      seq_q, seq_d;
   logic                  wr_en_q, wr_en_d;
   logic [DATA_WIDTH:0]   wr_data_q, wr_data_d;
   logic                  ovf_q, ovf_d;

   logic                  s_ready;
   logic                  beat;
   logic                  space_ok;
   logic                  wr_req;
   logic [DATA_WIDTH:0]   wr_word;
   logic [DATA_WIDTH:0]   trailer_word;
   logic [CW-1:0]         occ_after;

   // An unregistered-by-FIFO pending write still occupies a slot.
   assign occ_after    = CW'(bus.fifo_count) + CW'(wr_en_q) + NEED;
   assign space_ok     = (occ_after <= CAP);
   assign beat         = s_ready & bus.s_valid;
   assign trailer_word = (DATA_WIDTH+1)'(pack_trailer(seq_q, wc_q, DATA_WIDTH));

   always_ff @(posedge wr_clk or negedge wr_rst_n) begin
      if (!wr_rst_n) begin
         state_q   <= ST_IDLE;
         wc_q      <= '0;
         seq_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_data_q <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         wc_q      <= wc_d;
         seq_q     <= seq_d;
         wr_en_q   <= wr_en_d;
         wr_data_q <= wr_data_d;
         ovf_q     <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wc_d    = wc_q;
      seq_d   = seq_q;
      case (state_q)
         ST_IDLE: begin
            if (space_ok) state_d = ST_PAYLOAD;
         end
         ST_PAYLOAD: begin
            if (beat) wc_d = wc_q + LEN_W'(1);
            // A flush only closes a frame that holds at least one word.
            if ((beat && (wc_d == FULL_LEN)) || (bus.flush && (wc_d != '0)))
               state_d = ST_TRAILER;
         end
         ST_TRAILER: begin
            state_d = ST_IDLE;
            wc_d    = '0;
            seq_d   = seq_q + SEQ_W'(1);
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      s_ready   = (state_q == ST_PAYLOAD);
      wr_req    = (s_ready && bus.s_valid) || (state_q == ST_TRAILER);
      wr_word   = (state_q == ST_TRAILER) ? trailer_word : {1'b0, bus.s_data};
      // A write into a full FIFO is dropped but the framing still advances.
      wr_en_d   = wr_req & ~bus.fifo_full;
      wr_data_d = wr_en_d ? wr_word : wr_data_q;
      ovf_d     = ovf_q | (wr_req & bus.fifo_full);
   end

   assign bus.s_ready      = s_ready;
   assign bus.fifo_wr_en   = wr_en_q;
   assign bus.fifo_wr_data = wr_data_q;
   assign bus.frame_seq    = seq_q;
   assign bus.overflow_err = ovf_q;
   assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_fifo_frame_writer.sv
// Directed bench for fifo_frame_writer: framing, flush, space gating,
// overflow guard and mid-frame reset.
module tb_fifo_frame_writer;
   import fifo_frame_writer_pkg::*;

   localparam int DW = 16;
   localparam int AW = 4;
   localparam int FL = 8;
   localparam int W  = DW + 1;

   logic wr_clk   = 1'b0;
   logic wr_rst_n = 1'b0;
   int   tests_run = 0;
   int   fails     = 0;
   int   cyc       = 0;

   logic [W-1:0] got_q[$];
   int           got_t[$];
   logic [W-1:0] exp_q[$];

   always #5 wr_clk = ~wr_clk;

   fifo_frame_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   fifo_frame_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_LEN(FL)) dut (
      .wr_clk   (wr_clk),
      .wr_rst_n (wr_rst_n),
      .bus      (bus)
   );

   // Write monitor: records every FIFO write and the cycle it happened in.
   initial begin
      forever begin
         @(posedge wr_clk);
         cyc = cyc + 1;
         #2;
         if (bus.fifo_wr_en === 1'b1) begin
            got_q.push_back(bus.fifo_wr_data);
            got_t.push_back(cyc);
         end
      end
   end

   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge wr_clk);
         #1;
      end
   endtask

   task automatic clear_capture();
      got_q.delete();
      got_t.delete();
      exp_q.delete();
   endtask

   // Presents n words base, base+1, ...; flush rides on the last accepted beat,
   // fifo_full is raised on the beat with index full_idx.
   task automatic drive_words(input int n, input logic [DW-1:0] base,
                              input bit flush_last, input int full_idx);
      int  i;
      int  guard;
      bit  acc;
      i = 0;
      guard = 0;
      while (i < n && guard < 100) begin
         bus.s_valid   = 1'b1;
         bus.s_data    = base + DW'(i);
         acc           = (bus.s_ready === 1'b1);
         bus.flush     = acc && flush_last && (i == n - 1);
         bus.fifo_full = acc && (i == full_idx);
         step(1);
         if (acc) i++;
         guard++;
      end
      bus.s_valid   = 1'b0;
      bus.flush     = 1'b0;
      bus.fifo_full = 1'b0;
      tests_run++;
      if (i != n) begin
         fails++;
         $display("FAIL drive_words accepted=%0d required=%0d", i, n);
      end
   endtask

   task automatic test_reset();
      tests_run++;
      if ({bus.s_ready, bus.fifo_wr_en, bus.overflow_err} !== 3'b000) begin
         fails++;
         $display("FAIL reset_flags got=%b required=000",
                  {bus.s_ready, bus.fifo_wr_en, bus.overflow_err});
      end
      tests_run++;
      if (bus.fifo_wr_data !== '0 || bus.frame_seq !== 8'd0 || bus.dbg_state !== ST_IDLE) begin
         fails++;
         $display("FAIL reset_values data=%h seq=%0d state=%0d required 0/0/IDLE",
                  bus.fifo_wr_data, bus.frame_seq, bus.dbg_state);
      end
   endtask

   task automatic test_full_frame();
      clear_capture();
      drive_words(8, 16'h0001, 1'b0, -1);
      step(3);
      for (int k = 1; k <= 8; k++) exp_q.push_back(W'(k));
      exp_q.push_back(17'h10008);
      tests_run++;
      if (got_q.size() != exp_q.size()) begin
         fails++;
         $display("FAIL full_frame_count got=%0d required=%0d", got_q.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
         tests_run++;
         if (got_q[k] !== exp_q[k] || got_t[k] != got_t[0] + k) begin
            fails++;
            $display("FAIL full_frame_word[%0d] got=%h@%0d required=%h@%0d",
                     k, got_q[k], got_t[k], exp_q[k], got_t[0] + k);
         end
      end
      tests_run++;
      if (bus.frame_seq !== 8'd1) begin
         fails++;
         $display("FAIL full_frame_seq got=%0d required=1", bus.frame_seq);
      end
   endtask

   task automatic test_early_flush();
      clear_capture();
      drive_words(3, 16'h0011, 1'b0, -1);
      bus.flush = 1'b1;
      step(1);
      bus.flush = 1'b0;
      step(3);
      exp_q.push_back(17'h00011);
      exp_q.push_back(17'h00012);
      exp_q.push_back(17'h00013);
      exp_q.push_back(17'h10103);
      tests_run++;
      if (got_q.size() != exp_q.size()) begin
         fails++;
         $display("FAIL early_flush_count got=%0d required=%0d", got_q.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
         tests_run++;
         if (got_q[k] !== exp_q[k]) begin
            fails++;
            $display("FAIL early_flush_word[%0d] got=%h required=%h", k, got_q[k], exp_q[k]);
         end
      end
      tests_run++;
      if (bus.frame_seq !== 8'd2) begin
         fails++;
         $display("FAIL early_flush_seq got=%0d required=2", bus.frame_seq);
      end
   endtask

   task automatic test_ignored_flush();
      clear_capture();
      bus.flush = 1'b1;
      step(1);
      bus.flush = 1'b0;
      step(3);
      tests_run++;
      if (got_q.size() != 0 || bus.frame_seq !== 8'd2 || bus.dbg_state !== ST_PAYLOAD) begin
         fails++;
         $display("FAIL empty_flush writes=%0d seq=%0d state=%0d required 0/2/PAYLOAD",
                  got_q.size(), bus.frame_seq, bus.dbg_state);
      end
   endtask

   task automatic test_flush_with_beat();
      clear_capture();
      drive_words(5, 16'h0021, 1'b1, -1);
      step(3);
      for (int k = 0; k < 5; k++) exp_q.push_back(W'(16'h0021 + k));
      exp_q.push_back(17'h10205);
      tests_run++;
      if (got_q.size() != exp_q.size()) begin
         fails++;
         $display("FAIL flush_beat_count got=%0d required=%0d", got_q.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
         tests_run++;
         if (got_q[k] !== exp_q[k]) begin
            fails++;
            $display("FAIL flush_beat_word[%0d] got=%h required=%h", k, got_q[k], exp_q[k]);
         end
      end
   endtask

   task automatic test_space_gating();
      int bad;
      clear_capture();
      bus.fifo_count = 5'd8;
      drive_words(1, 16'h0031, 1'b1, -1);
      step(2);
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         if (bus.s_ready !== 1'b0 || bus.dbg_state !== ST_IDLE) bad++;
         step(1);
      end
      tests_run++;
      if (bad != 0) begin
         fails++;
         $display("FAIL gate_count8 cycles_ready=%0d required=0", bad);
      end
      bus.fifo_count = 5'd7;
      tests_run++;
      if (bus.s_ready !== 1'b0) begin
         fails++;
         $display("FAIL gate_count7_same_cycle s_ready=%b required=0", bus.s_ready);
      end
      step(1);
      tests_run++;
      if (bus.s_ready !== 1'b1 || bus.dbg_state !== ST_PAYLOAD) begin
         fails++;
         $display("FAIL gate_count7_admit s_ready=%b state=%0d required 1/PAYLOAD",
                  bus.s_ready, bus.dbg_state);
      end
      // Count 7 plus a pending trailer write: needs one more cycle to admit.
      drive_words(1, 16'h0032, 1'b1, -1);
      step(1);
      tests_run++;
      if (bus.fifo_wr_en !== 1'b1 || bus.s_ready !== 1'b0) begin
         fails++;
         $display("FAIL gate_pending_trailer wr_en=%b s_ready=%b required 1/0",
                  bus.fifo_wr_en, bus.s_ready);
      end
      step(1);
      tests_run++;
      if (bus.s_ready !== 1'b0) begin
         fails++;
         $display("FAIL gate_pending_block s_ready=%b required=0", bus.s_ready);
      end
      step(1);
      tests_run++;
      if (bus.s_ready !== 1'b1) begin
         fails++;
         $display("FAIL gate_pending_release s_ready=%b required=1", bus.s_ready);
      end
      // Count 6 plus the pending write sums to exactly the depth: admitted.
      bus.fifo_count = 5'd6;
      drive_words(1, 16'h0033, 1'b1, -1);
      step(2);
      tests_run++;
      if (bus.s_ready !== 1'b1) begin
         fails++;
         $display("FAIL gate_count6_pending s_ready=%b required=1", bus.s_ready);
      end
      step(2);
      bus.fifo_count = 5'd0;
      exp_q.push_back(17'h00031);
      exp_q.push_back(17'h10301);
      exp_q.push_back(17'h00032);
      exp_q.push_back(17'h10401);
      exp_q.push_back(17'h00033);
      exp_q.push_back(17'h10501);
      tests_run++;
      if (got_q.size() != exp_q.size()) begin
         fails++;
         $display("FAIL gate_write_count got=%0d required=%0d", got_q.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
         tests_run++;
         if (got_q[k] !== exp_q[k]) begin
            fails++;
            $display("FAIL gate_word[%0d] got=%h required=%h", k, got_q[k], exp_q[k]);
         end
      end
   endtask

   task automatic test_forced_full();
      clear_capture();
      drive_words(8, 16'h0041, 1'b0, 3);
      tests_run++;
      if (bus.overflow_err !== 1'b1) begin
         fails++;
         $display("FAIL ovf_set got=%b required=1", bus.overflow_err);
      end
      step(4);
      for (int k = 0; k < 8; k++) if (k != 3) exp_q.push_back(W'(16'h0041 + k));
      exp_q.push_back(17'h10608);
      tests_run++;
      if (got_q.size() != exp_q.size()) begin
         fails++;
         $display("FAIL ovf_write_count got=%0d required=%0d", got_q.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
         tests_run++;
         if (got_q[k] !== exp_q[k]) begin
            fails++;
            $display("FAIL ovf_word[%0d] got=%h required=%h", k, got_q[k], exp_q[k]);
         end
      end
      if (got_t.size() >= 4) begin
         tests_run++;
         if (got_t[3] != got_t[2] + 2) begin
            fails++;
            $display("FAIL ovf_dropped_slot got_cycle=%0d required=%0d", got_t[3], got_t[2] + 2);
         end
      end
      tests_run++;
      if (bus.overflow_err !== 1'b1 || bus.frame_seq !== 8'd7) begin
         fails++;
         $display("FAIL ovf_sticky ovf=%b seq=%0d required 1/7", bus.overflow_err, bus.frame_seq);
      end
   endtask

   task automatic test_reset_mid_frame();
      drive_words(4, 16'h0051, 1'b0, -1);
      wr_rst_n = 1'b0;
      #1;
      tests_run++;
      if ({bus.s_ready, bus.fifo_wr_en, bus.overflow_err} !== 3'b000 ||
          bus.fifo_wr_data !== '0 || bus.frame_seq !== 8'd0 || bus.dbg_state !== ST_IDLE) begin
         fails++;
         $display("FAIL midreset rdy/wen/ovf=%b data=%h seq=%0d state=%0d required all 0/IDLE",
                  {bus.s_ready, bus.fifo_wr_en, bus.overflow_err}, bus.fifo_wr_data,
                  bus.frame_seq, bus.dbg_state);
      end
      @(negedge wr_clk);
      @(negedge wr_clk);
      wr_rst_n = 1'b1;
      step(1);
      clear_capture();
      drive_words(2, 16'h0061, 1'b1, -1);
      step(3);
      exp_q.push_back(17'h00061);
      exp_q.push_back(17'h00062);
      exp_q.push_back(17'h10002);
      tests_run++;
      if (got_q.size() != exp_q.size()) begin
         fails++;
         $display("FAIL postreset_count got=%0d required=%0d", got_q.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
         tests_run++;
         if (got_q[k] !== exp_q[k]) begin
            fails++;
            $display("FAIL postreset_word[%0d] got=%h required=%h", k, got_q[k], exp_q[k]);
         end
      end
   endtask

   initial begin
      bus.s_data     = '0;
      bus.s_valid    = 1'b0;
      bus.flush      = 1'b0;
      bus.fifo_full  = 1'b0;
      bus.fifo_count = '0;
      wr_rst_n       = 1'b0;
      step(2);
      test_reset();
      @(negedge wr_clk);
      wr_rst_n = 1'b1;
      step(1);
      test_full_frame();
      test_early_flush();
      test_ignored_flush();
      test_flush_with_beat();
      test_space_gating();
      test_forced_full();
      test_reset_mid_frame();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout tests_run=%0d", tests_run);
      $fatal(1, "timeout");
   end

endmodule
